gate_reduce_unit: RTL and testbench
===================================

# gate_reduce_unit

Parametrised successor to the single-bit AND cell in the Tiny Tapeout user project. Combines two WIDTH-bit operands with a selectable gate (AND/OR/XOR/NAND) and registers the result. A reduce mode folds a stream of DEPTH operand beats into one result, using a counter and a two-state FSM. Sits between the `ui_in`/`uio_in` pin decode and the `uo_out` drive in the top-level wrapper.

## Interface

- WIDTH, 4: operand and result width in bits (≥1).
- DEPTH, 4: beats per reduction (≥1); counter width is clog2(DEPTH+1).

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (single mode only; ignored in reduce mode).
- op  input  2  gate select: 00 AND, 01 OR, 10 XOR, 11 NAND.
- mode  input  1  0 = single, 1 = reduce.
- start  input  1  begins a reduction when idle and mode=1.
- in_valid  input  1  operand beat qualifier.
- y  output  WIDTH  registered result; holds its value until the next update.
- y_valid  output  1  one-cycle pulse when y updates.
- busy  output  1  high while a reduction is in progress.
- done  output  1  one-cycle pulse with y_valid at the end of a reduction.

## Operation

- FSM states: IDLE, ACCUM. Reset state is IDLE.
- Reset values: y=0, y_valid=0, busy=0, done=0, count=0, acc=0.
- IDLE, mode=0, in_valid=1:
  - y <= a op b, where NAND = ~(a&b).
  - y_valid pulses; state is unchanged.
  - start is ignored in single mode.
- IDLE, mode=1, start=1:
  - Latch op into op_r.
  - Load acc with the identity value: all-ones for AND/NAND, zero for OR/XOR.
  - Set count=0 and go to ACCUM.
  - If in_valid is high in the same cycle, that beat is discarded; start has priority.
- IDLE, mode=1, start=0: in_valid is ignored and no output changes.
- ACCUM, in_valid=1:
  - acc <= acc g a, with g = AND for op_r 00/11, OR for 01, XOR for 10.
  - count increments.
- ACCUM, in_valid=0: hold. Gaps of any length are allowed.
- Final beat (count = DEPTH-1 with in_valid=1):
  - Next cycle: y = final acc, inverted if op_r=11.
  - y_valid=1 and done=1 for one cycle.
  - State returns to IDLE and busy drops.
- In ACCUM, changes on mode, op and start are ignored. op_r and the beat count are unaffected.
- Reset asserted mid-reduction: immediate return to IDLE with all reset values. The partial accumulation is lost.
- DEPTH=1: the first beat after start completes the reduction.

## Timing

- Single-mode latency: 1 cycle from the in_valid edge to y/y_valid.
- Reduce-mode latency: 1 cycle from the accepted final beat to y/y_valid/done.
- busy is high from the cycle after start through the final-beat cycle, and low in the cycle y_valid/done are asserted.
- The earliest new start is accepted in the same cycle done is high, since the FSM is already in IDLE.
- Throughput:
  - Single mode: one result per cycle.
  - Reduce mode: DEPTH+1 cycles minimum per result, including the start cycle.
- y_valid and done are never high for two consecutive cycles from a single reduction.

## Test plan

WIDTH=4, DEPTH=4.

- Reset: hold rst_n=0 with random inputs. Required: y=0000, y_valid=0, busy=0, done=0. Release rst_n and confirm the outputs stay idle.
- Single mode: a=1100, b=1010 with op=00/01/10/11 on consecutive cycles with in_valid=1. Required: y=1000/1110/0110/0111, each one cycle later, y_valid high for 4 cycles. done stays 0.
- Reduce OR: op=01, start, then beats a=0001, 0010, (2-cycle gap), 0000, 1000. Required: busy high throughout. The cycle after the 4th beat gives y=1011, y_valid=1, done=1, busy=0.
- Reduce NAND: op=11, beats 1111, 1110, 0111, 1111. Required: y=1001 with done.
  - Also set in_valid together with start. Required: that beat is discarded and 4 further beats are needed.
- Interference: during ACCUM, pulse start, flip mode to 0 and change op to 10. Required: no restart, beat count continues, and the result uses the latched op.
- Mid-operation reset: after 2 reduce beats, pulse rst_n low. Required: immediate busy=0, y=0000. A fresh AND reduction of 1111, 1101, 0111, 1111 then yields y=0101.

Source files
------------

// File: rtl/gate_reduce_unit.sv
// gate_reduce_unit: bitwise gate (AND/OR/XOR/NAND) over two WIDTH-bit operands with a
// registered result, plus a reduce mode that folds DEPTH operand beats into one result.
//
// Single mode (mode=0): every in_valid cycle in IDLE registers y = a op b and pulses y_valid.
// Reduce mode (mode=1): start in IDLE latches op, seeds the accumulator with the gate's
// identity and enters ACCUM. Each in_valid beat folds operand a into the accumulator.
// The final beat's result lands on y one cycle later with y_valid and done.
// Inputs other than in_valid/a are ignored while a reduction is in progress.

module gate_reduce_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             mode,
    input  logic             start,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             busy,
    output logic             done
);

    // Counter wide enough to hold 0..DEPTH.
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // Count value at which an accepted beat is the last one of the reduction.
    localparam logic [CntW-1:0] LastBeat = CntW'(DEPTH - 1);

    // Gate select encoding.
    localparam logic [1:0] OpAnd  = 2'b00;
    localparam logic [1:0] OpOr   = 2'b01;
    localparam logic [1:0] OpXor  = 2'b10;
    localparam logic [1:0] OpNand = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Two-operand gate used in single mode.
    function automatic logic [WIDTH-1:0] gate_fn(
        input logic [WIDTH-1:0] lhs,
        input logic [WIDTH-1:0] rhs,
        input logic [1:0]       sel
    );
        logic [WIDTH-1:0] res;
        unique case (sel)
            OpAnd:   res = lhs & rhs;
            OpOr:    res = lhs | rhs;
            OpXor:   res = lhs ^ rhs;
            OpNand:  res = ~(lhs & rhs);
            default: res = '0;
        endcase
        return res;
    endfunction

    // One accumulation step. NAND folds with AND; the inversion is applied once at the end
    // so that the result is the NAND of all beats rather than a chained NAND.
    function automatic logic [WIDTH-1:0] fold_fn(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] beat,
        input logic [1:0]       sel
    );
        logic [WIDTH-1:0] res;
        unique case (sel)
            OpOr:    res = acc | beat;
            OpXor:   res = acc ^ beat;
            default: res = acc & beat;
        endcase
        return res;
    endfunction

    // Seed value that leaves the first beat unchanged under fold_fn.
    function automatic logic [WIDTH-1:0] identity_fn(input logic [1:0] sel);
        logic [WIDTH-1:0] res;
        unique case (sel)
            OpOr, OpXor: res = '0;
            default:     res = '1;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             done_q, done_d;

    // Accumulator value including the current beat, using the latched op.
    logic [WIDTH-1:0] acc_next;

    // Next-state and next-output decode; pulses default low, everything else holds.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        op_d      = op_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        done_d    = 1'b0;
        acc_next  = fold_fn(acc_q, a, op_q);

        unique case (state_q)
            StIdle: begin
                if (!mode) begin
                    // Single mode: start is ignored, each valid beat gives a result.
                    if (in_valid) begin
                        y_d       = gate_fn(a, b, op);
                        y_valid_d = 1'b1;
                    end
                end else if (start) begin
                    // Start wins over a coincident in_valid; that beat is dropped.
                    op_d    = op;
                    acc_d   = identity_fn(op);
                    count_d = '0;
                    state_d = StAccum;
                end
            end

            StAccum: begin
                // mode, op and start are deliberately not looked at here.
                if (in_valid) begin
                    acc_d = acc_next;
                    if (count_q == LastBeat) begin
                        y_d       = (op_q == OpNand) ? ~acc_next : acc_next;
                        y_valid_d = 1'b1;
                        done_d    = 1'b1;
                        count_d   = '0;
                        state_d   = StIdle;
                    end else begin
                        count_d = count_q + CntW'(1);
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Control state: FSM, beat counter and latched op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            op_q    <= OpAnd;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    // Datapath state: accumulator, result register and its strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            done_q    <= done_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign done    = done_q;
    // ACCUM spans exactly the cycle after start through the final-beat cycle.
    assign busy    = (state_q == StAccum);

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Self-checking bench for gate_reduce_unit (WIDTH=4, DEPTH=4): directed scenarios followed
// by randomized single/reduce transactions checked against a column-counting reference.

module tb_gate_reduce_unit;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             mode;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    // Beats accepted in the current reduction, for the reference model.
    logic [WIDTH-1:0] beats[$];

    gate_reduce_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .mode     (mode),
        .start    (start),
        .in_valid (in_valid),
        .y        (y),
        .y_valid  (y_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-mode reference: truth of the named gate.
    function automatic logic [WIDTH-1:0] ref_single(input logic [1:0] g,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] z);
        case (g)
            2'd0:    return x & z;
            2'd1:    return x | z;
            2'd2:    return x ^ z;
            default: return ~(x & z);
        endcase
    endfunction

    // Reduce reference: per bit column, count ones across all beats and decide from the count.
    function automatic logic [WIDTH-1:0] ref_reduce(input logic [1:0] g);
        logic [WIDTH-1:0] r;
        for (int j = 0; j < WIDTH; j++) begin
            int ones = 0;
            foreach (beats[i]) ones += int'(beats[i][j]);
            case (g)
                2'd0:    r[j] = (ones == beats.size());
                2'd1:    r[j] = (ones > 0);
                2'd2:    r[j] = (ones % 2 == 1);
                default: r[j] = (ones != beats.size());
            endcase
        end
        return r;
    endfunction

    task automatic idle_inputs();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Present one reduce beat for a single cycle.
    task automatic beat(input logic [WIDTH-1:0] v);
        a        = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic begin_reduce(input logic [1:0] g);
        mode     = 1'b1;
        op       = g;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_y;
        logic [1:0]       g;

        // ---------------- Reset with random inputs ----------------
        rst_n    = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        op       = 2'($urandom);
        mode     = 1'($urandom);
        start    = 1'($urandom);
        in_valid = 1'($urandom);
        step();
        step();
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        idle_inputs();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_y", y, 0);
        check("post_rst_y_valid", y_valid, 0);
        check("post_rst_busy", busy, 0);

        // ---------------- Single mode, all four gates back to back ----------------
        mode     = 1'b0;
        a        = 4'b1100;
        b        = 4'b1010;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = 2'(k);
            step();
            check($sformatf("single_y_op%0d", k), y, ref_single(2'(k), 4'b1100, 4'b1010));
            check($sformatf("single_yv_op%0d", k), y_valid, 1);
            check($sformatf("single_done_op%0d", k), done, 0);
        end
        in_valid = 1'b0;
        step();
        check("single_hold_y", y, 4'b0111);
        check("single_hold_yv", y_valid, 0);

        // mode=1 without start: in_valid must be ignored.
        mode     = 1'b1;
        op       = 2'd1;
        a        = 4'b1111;
        in_valid = 1'b1;
        step();
        check("idle_reduce_nostart_yv", y_valid, 0);
        check("idle_reduce_nostart_busy", busy, 0);
        check("idle_reduce_nostart_y", y, 4'b0111);
        in_valid = 1'b0;

        // ---------------- Reduce OR with a 2-cycle gap ----------------
        begin_reduce(2'd1);
        check("or_busy_start", busy, 1);
        beat(4'b0001);
        check("or_busy_b1", busy, 1);
        beat(4'b0010);
        step();
        step();
        check("or_busy_gap", busy, 1);
        check("or_yv_gap", y_valid, 0);
        beat(4'b0000);
        check("or_busy_b3", busy, 1);
        beat(4'b1000);
        check("or_y", y, 4'b1011);
        check("or_yv", y_valid, 1);
        check("or_done", done, 1);
        check("or_busy_end", busy, 0);
        step();
        check("or_yv_single_pulse", y_valid, 0);
        check("or_done_single_pulse", done, 0);

        // ---------------- Reduce NAND; beat coincident with start is dropped ----------------
        mode     = 1'b1;
        op       = 2'd3;
        start    = 1'b1;
        a        = 4'b0000;
        in_valid = 1'b1;
        step();
        idle_inputs();
        check("nand_busy_start", busy, 1);
        beat(4'b1111);
        beat(4'b1110);
        beat(4'b0111);
        check("nand_not_done_3", done, 0);
        check("nand_busy_3", busy, 1);
        beat(4'b1111);
        check("nand_y", y, 4'b1001);
        check("nand_done", done, 1);
        check("nand_yv", y_valid, 1);

        // ---------------- Interference during ACCUM ----------------
        begin_reduce(2'd1);
        beat(4'b0011);
        start = 1'b1;
        mode  = 1'b0;
        op    = 2'd2;
        b     = 4'b1111;
        step();
        check("intf_busy", busy, 1);
        check("intf_yv", y_valid, 0);
        beat(4'b0110);
        check("intf_yv_b2", y_valid, 0);
        beat(4'b1000);
        beat(4'b0000);
        check("intf_done", done, 1);
        check("intf_y_latched_or", y, 4'b1111);
        idle_inputs();
        mode = 1'b1;
        step();

        // ---------------- Mid-reduction reset ----------------
        begin_reduce(2'd1);
        beat(4'b0001);
        beat(4'b0010);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_y", y, 0);
        check("midrst_yv", y_valid, 0);
        step();
        rst_n = 1'b1;
        begin_reduce(2'd0);
        beat(4'b1111);
        beat(4'b1101);
        beat(4'b0111);
        beat(4'b1111);
        check("midrst_and_y", y, 4'b0101);
        check("midrst_and_done", done, 1);

        // ---------------- Randomized transactions ----------------
        // Each transaction starts in the cycle right after the previous result, so starts
        // coinciding with done are exercised too.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                mode     = 1'b0;
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                g        = 2'($urandom);
                op       = g;
                start    = 1'($urandom);
                in_valid = 1'b1;
                exp_y    = ref_single(g, a, b);
                step();
                check("rnd_single_y", y, exp_y);
                check("rnd_single_yv", y_valid, 1);
                check("rnd_single_busy", busy, 0);
                idle_inputs();
            end else begin
                g        = 2'($urandom);
                mode     = 1'b1;
                op       = g;
                start    = 1'b1;
                in_valid = 1'($urandom);
                a        = WIDTH'($urandom);
                step();
                check("rnd_red_busy_start", busy, 1);
                beats.delete();
                while (beats.size() < DEPTH) begin
                    in_valid = ($urandom_range(0, 2) != 0);
                    a        = WIDTH'($urandom);
                    b        = WIDTH'($urandom);
                    op       = 2'($urandom);
                    mode     = 1'($urandom);
                    start    = 1'($urandom);
                    if (in_valid) beats.push_back(a);
                    step();
                    if (beats.size() < DEPTH) begin
                        check("rnd_red_busy", busy, 1);
                        check("rnd_red_yv_early", y_valid, 0);
                    end
                end
                exp_y = ref_reduce(g);
                check("rnd_red_y", y, exp_y);
                check("rnd_red_done", done, 1);
                check("rnd_red_yv", y_valid, 1);
                check("rnd_red_busy_end", busy, 0);
                idle_inputs();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
